// File: rtl/checked_csa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : checked_csa_pipe
// Purpose  : Two-stage, valid/ready pipelined carry-select adder that checks
//            its own result. The primary path computes a + b with carry-in 0.
//            An independent path computes ~a + ~b + 1, which must equal the
//            bitwise complement of the primary {cout, s}. Sum parity is
//            predicted from the operand parity bits and the carry vector.
//            Sticky error status and a saturating error count are kept.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, a, b, pa, pb        - operand side
//            out_valid/out_ready, s, cout, ps, err  - result side
//            err_sticky, err_count, clr_err         - error bookkeeping
//            inj (only with CHECKED_CSA_FAULT_INJECT_EN) - XOR mask that is
//            applied to the primary sum
// Config   : `define CHECKED_CSA_FAULT_INJECT_EN adds the inj port
// Revision : 1.0 - initial release
// ============================================================================
module checked_csa_pipe #(
  parameter int WIDTH     = 78,
  parameter int BLOCK     = 13,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 pa,
  input  logic                 pb,
`ifdef CHECKED_CSA_FAULT_INJECT_EN
  input  logic [WIDTH-1:0]     inj,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     s,
  output logic                 cout,
  output logic                 ps,
  output logic [2:0]           err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BLOCK:0]       BLK_ONE = {{BLOCK{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic w_adv1, w_adv2;
  logic w_load1, w_load2;

  assign w_adv2   = !v2_q || out_ready;
  assign w_adv1   = !v1_q || w_adv2;
  assign in_ready = w_adv1;
  assign w_load1  = in_valid && w_adv1;
  assign w_load2  = v1_q && w_adv2;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (w_adv1) v1_d = in_valid;
    if (w_adv2) v2_d = v1_q;
  end

  // --------------------------------------------------------------------------
  // Stage 1: operand registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] a_q, b_q;
  logic             pa_q, pb_q;
`ifdef CHECKED_CSA_FAULT_INJECT_EN
  logic [WIDTH-1:0] inj_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      pa_q  <= 1'b0;
      pb_q  <= 1'b0;
`ifdef CHECKED_CSA_FAULT_INJECT_EN
      inj_q <= '0;
`endif
    end else if (w_load1) begin
      a_q   <= a;
      b_q   <= b;
      pa_q  <= pa;
      pb_q  <= pb;
`ifdef CHECKED_CSA_FAULT_INJECT_EN
      inj_q <= inj;
`endif
    end
  end

  // Per-block speculative sums, carry-in 0 and 1, for both paths. Bit BLOCK
  // of each entry is the block carry-out.
  logic [NBLK-1:0][BLOCK:0] w_p0, w_p1;  // primary: a + b
  logic [NBLK-1:0][BLOCK:0] w_c0, w_c1;  // complement: ~a + ~b

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic [BLOCK-1:0] w_ab, w_bb;
    assign w_ab    = a_q[j*BLOCK +: BLOCK];
    assign w_bb    = b_q[j*BLOCK +: BLOCK];
    assign w_p0[j] = {1'b0, w_ab} + {1'b0, w_bb};
    assign w_p1[j] = {1'b0, w_ab} + {1'b0, w_bb} + BLK_ONE;
    assign w_c0[j] = {1'b0, ~w_ab} + {1'b0, ~w_bb};
    assign w_c1[j] = {1'b0, ~w_ab} + {1'b0, ~w_bb} + BLK_ONE;
  end

  // --------------------------------------------------------------------------
  // Block carry ripple: each block carry selects the next block's sum.
  // --------------------------------------------------------------------------
  logic [NBLK:0]    w_pcar, w_ccar;
  logic [WIDTH-1:0] w_sum_p, w_sum_c;

  always_comb begin
    w_pcar    = '0;
    w_ccar    = '0;
    w_sum_p   = '0;
    w_sum_c   = '0;
    w_pcar[0] = 1'b0;
    w_ccar[0] = 1'b1;
    for (int j = 0; j < NBLK; j++) begin
      if (w_pcar[j]) begin
        w_sum_p[j*BLOCK +: BLOCK] = w_p1[j][BLOCK-1:0];
        w_pcar[j+1]               = w_p1[j][BLOCK];
      end else begin
        w_sum_p[j*BLOCK +: BLOCK] = w_p0[j][BLOCK-1:0];
        w_pcar[j+1]               = w_p0[j][BLOCK];
      end
      if (w_ccar[j]) begin
        w_sum_c[j*BLOCK +: BLOCK] = w_c1[j][BLOCK-1:0];
        w_ccar[j+1]               = w_c1[j][BLOCK];
      end else begin
        w_sum_c[j*BLOCK +: BLOCK] = w_c0[j][BLOCK-1:0];
        w_ccar[j+1]               = w_c0[j][BLOCK];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checks
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_s_out;
  logic             w_cpar;
  logic             w_ps;
  logic [2:0]       w_err;

`ifdef CHECKED_CSA_FAULT_INJECT_EN
  assign w_s_out = w_sum_p ^ inj_q;
`else
  assign w_s_out = w_sum_p;
`endif

  // Carry into bit i is a[i]^b[i]^sum[i] of the unaltered adder, so the
  // parity of the carry vector folds into one reduction.
  assign w_cpar   = ^(a_q ^ b_q ^ w_sum_p);
  assign w_ps     = pa_q ^ pb_q ^ w_cpar;

  // ~a + ~b + 1 equals ~(a + b) over WIDTH+1 bits.
  assign w_err[0] = (w_s_out != ~w_sum_c) || (w_pcar[NBLK] != ~w_ccar[NBLK]);
  assign w_err[1] = (^w_s_out) != w_ps;
  assign w_err[2] = (pa_q != ^a_q) || (pb_q != ^b_q);

  // --------------------------------------------------------------------------
  // Stage 2: result registers and error bookkeeping
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     s_q;
  logic                 cout_q, ps_q;
  logic [2:0]           err_q;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // A clear takes effect first so a coincident error is still recorded.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_err) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (w_load2 && (w_err != 3'b000)) begin
      sticky_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ps_q     <= 1'b0;
      err_q    <= 3'b000;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      if (w_load2) begin
        s_q    <= w_s_out;
        cout_q <= w_pcar[NBLK];
        ps_q   <= w_ps;
        err_q  <= w_err;
      end
    end
  end

  assign out_valid  = v2_q;
  assign s          = s_q;
  assign cout       = cout_q;
  assign ps         = ps_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule
`default_nettype wire
